digit_scanner: RTL
==================

# digit_scanner

Time-multiplexed 4-digit display driver for the parking-system front panel, sitting directly upstream of the BCD-to-7-segment decoder. It converts a binary count, such as the free-space count, to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It then scans the digits onto the shared segment bus, driving the decoder's 4-bit BCD input and the board's active-low anode lines. Conversion and scanning run concurrently, and the displayed value changes atomically.

## Interface
Parameters:
- REFRESH_DIV, default 100000, clock cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range ≥ 2.
- BIN_W, default 14, width of the binary input; fixed at 14 for 0..16383.

Ports:
- clk, in, 1, system clock; all state changes on its rising edge.
- rst_n, in, 1, reset. One clock; reset is asynchronous and active-low.
- value, in, 14, binary number to display; sampled only on an accepted load.
- load, in, 1, single-cycle request to convert and display value.
- blank_lz, in, 1, leading-zero blanking enable; sampled live every cycle.
- busy, out, 1, high while a conversion is in progress.
- bcd, out, 4, BCD digit for the currently selected position; feeds the 7-seg decoder.
- an, out, 4, active-low anode select; an[0] is the ones digit, an[3] the thousands digit.

## Operation
- Conversion FSM has three states: IDLE, SHIFT, COMMIT.
  - IDLE: when load = 1, capture value into the shift register. If value > 9999, saturate to 9999. Clear the 16-bit BCD accumulator, zero the iteration counter, and go to SHIFT.
  - SHIFT: perform one iteration per cycle. First add 3 to every BCD nibble ≥ 5, then shift {bcd_acc, bin} left by one. After the 14th iteration, go to COMMIT.
  - COMMIT: copy bcd_acc into the display register digits[15:0] in a single cycle, then go to IDLE.
- busy = 1 whenever the state is not IDLE.
- load asserted while busy is ignored. It is neither queued nor allowed to restart the conversion.
- The display register changes only in COMMIT, so the scanner never shows a partial conversion.
- Scanner:
  - A prescaler counts 0..REFRESH_DIV-1 and wraps.
  - At the terminal count, the digit index (2 bits) increments, wrapping from 3 to 0.
  - Scan order is 0, 1, 2, 3, 0, and so on.
- Output decode is combinational from registers only; there is no path from value, load, or blank_lz... except blank_lz, which feeds the an decode.
  - bcd = digits[4·idx+3 : 4·idx].
  - an = ~(1 << idx), unless that position is blanked, in which case an = 4'b1111.
- Blanking: when blank_lz = 1, position k (k = 1..3) is blanked if digits k..3 are all zero.
  - The ones digit is never blanked.
  - bcd is still driven with the digit value while its position is blanked.
- The scanner runs continuously, independent of the FSM.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - state IDLE, busy = 0
  - digits = 16'h0000
  - prescaler = 0, idx = 0
  - an = 4'b1110, bcd = 4'h0
- Reset mid-conversion aborts the conversion. The display returns to 0000, and the first load after reset release is accepted normally.
- Latency: for load sampled at edge E0:
  - busy rises after E0.
  - Iterations occur at E1..E14.
  - The commit occurs at E15.
  - The new digits and busy = 0 are visible after E15.
  - busy is high for exactly 15 cycles.
- A new load is accepted on the first edge at which busy = 0, so back-to-back conversions run every 16 cycles.
- Each digit slot lasts exactly REFRESH_DIV cycles. A full frame lasts 4·REFRESH_DIV cycles.
- idx changes on the same edge the prescaler wraps to 0. an and bcd change together, with no intermediate state.
- A COMMIT that lands in the middle of a slot updates the bcd of the currently lit slot on the next cycle. The slot timing is not disturbed.

## Test plan
- Reset: hold rst_n = 0 mid-scan. Required: an = 1110, bcd = 0, busy = 0 immediately (asynchronous), and the prescaler restarts at 0 after release.
- Basic conversion: REFRESH_DIV = 4, load with value = 1234. Required:
  - busy is high for 15 cycles.
  - Then an/bcd cycle through 1110/4, 1101/3, 1011/2, 0111/1, with each slot 4 cycles long.
- Saturation and extremes:
  - value = 16383 displays 9999.
  - value = 9999 displays 9999.
  - value = 0 displays 0000.
- Leading-zero blanking:
  - value = 507 with blank_lz = 1: the thousands slot shows an = 1111; the hundreds slot shows 5; the tens slot shows 0 (not blanked); the ones slot shows 7.
  - value = 0: only an = 1110 is ever asserted.
  - With blank_lz = 0, all four digits are shown.
- Load while busy: load 42, then pulse load with 9000 five cycles later. Required: the display shows 0042, busy stays high exactly 15 cycles, and the 9000 request is dropped.
- Reset mid-conversion: load 8888 and assert rst_n at cycle 7. Required: digits = 0000. After release, load 31 → display 0031 after 15 cycles.

Source files
------------

// File: rtl/digit_scanner.sv
// digit_scanner
// Converts a 14-bit binary count into four BCD digits using a sequential
// shift-add-3 (double-dabble) engine. It then time-multiplexes those digits
// onto a shared 7-segment decoder input with active-low anode selects.
//
// Ports:
//   clk      - system clock, all state changes on the rising edge
//   rst_n    - asynchronous active-low reset
//   value    - binary number to display, captured only on an accepted load
//   load     - single-cycle request to convert and display value
//   blank_lz - leading-zero blanking enable, used live by the anode decode
//   busy     - high while a conversion is in progress
//   bcd      - BCD digit of the currently selected position
//   an       - active-low anode select, an[0] = ones, an[3] = thousands

module digit_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int BIN_W       = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] value,
    input  logic             load,
    input  logic             blank_lz,
    output logic             busy,
    output logic [3:0]       bcd,
    output logic [3:0]       an
);

    localparam int               PW        = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]    PS_LAST   = PW'(REFRESH_DIV - 1);
    localparam int               IW        = $clog2(BIN_W);
    localparam logic [IW-1:0]    ITER_LAST = IW'(BIN_W - 1);
    localparam logic [BIN_W-1:0] SAT_MAX   = BIN_W'(9999);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [BIN_W-1:0]  bin_sr;
    logic [15:0]       bcd_acc;
    logic [15:0]       bcd_adj;
    logic [IW-1:0]     iter;
    logic [15:0]       digits;
    logic [PW-1:0]     prescaler;
    logic [1:0]        idx;
    logic [3:0]        digit_zero;
    logic              blanked;

    // Conversion state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A load is considered only in IDLE, so any request
    // that arrives mid-conversion is simply dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (iter == ITER_LAST) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Add-3 correction applied to every BCD nibble of 5 or more before the
    // shift, so that the nibble carries correctly into the next decade.
    always_comb begin
        bcd_adj = bcd_acc;
        for (int i = 0; i < 4; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath. digits is written only in COMMIT, so the scanner
    // never shows a half-converted value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr  <= '0;
            bcd_acc <= '0;
            iter    <= '0;
            digits  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr  <= (value > SAT_MAX) ? SAT_MAX : value;
                        bcd_acc <= '0;
                        iter    <= '0;
                    end
                end
                SHIFT: begin
                    bcd_acc <= {bcd_adj[14:0], bin_sr[BIN_W-1]};
                    bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
                    iter    <= iter + IW'(1);
                end
                COMMIT: begin
                    digits <= bcd_acc;
                end
                default: ;
            endcase
        end
    end

    // Refresh prescaler and digit index. The scanner runs freely and does not
    // depend on the conversion FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
            idx       <= idx + 2'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Output decode. A position k > 0 is blanked when it and every higher
    // digit are zero. The ones digit is always lit. bcd keeps carrying the
    // digit even when its anode is off.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            digit_zero[i] = (digits[4*i +: 4] == 4'd0);
        end

        case (idx)
            2'd3:    blanked = digit_zero[3];
            2'd2:    blanked = digit_zero[3] & digit_zero[2];
            2'd1:    blanked = digit_zero[3] & digit_zero[2] & digit_zero[1];
            default: blanked = 1'b0;
        endcase

        case (idx)
            2'd0:    bcd = digits[3:0];
            2'd1:    bcd = digits[7:4];
            2'd2:    bcd = digits[11:8];
            default: bcd = digits[15:12];
        endcase

        if (blank_lz && blanked) begin
            an = 4'b1111;
        end else begin
            an = ~(4'b0001 << idx);
        end
    end

endmodule
